simplez_cpu: RTL and testbench



---
 rtl/simplez_cpu.sv | 139 +++++++++++++
 tb/tb_simplez_cpu.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simplez_cpu.sv
// Simplez processor core: fetch, decode and execute of the eight-instruction
// Simplez set against an external single-port memory with a ready handshake.
module simplez_cpu #(
    parameter int                ADDRW    = 9,
    parameter int                LEDW     = 4,
    parameter logic [ADDRW-1:0]  RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDRW-1:0]     mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [ADDRW+2:0]     mem_wdata,
    input  logic [ADDRW+2:0]     mem_rdata,
    input  logic                 mem_ready,
    output logic [LEDW-1:0]      leds,
    output logic                 stop
);

    localparam int DATAW = ADDRW + 3;

    typedef enum logic [2:0] {
        OP_ST, OP_LD, OP_ADD, OP_BR, OP_BZ, OP_CLR, OP_DEC, OP_HALT
    } opcode_t;

    typedef enum logic [2:0] {
        S_I0, S_I1, S_O0, S_O1, S_H
    } state_t;

    state_t             state;
    logic [ADDRW-1:0]   pc;
    logic [DATAW-1:0]   ri;
    logic [DATAW-1:0]   ac;
    logic [DATAW-1:0]   temp;
    logic               z;

    opcode_t            co;
    logic [ADDRW-1:0]   cd;
    logic [DATAW-1:0]   ac_dec;
    logic [DATAW-1:0]   ac_sum;

    assign co        = opcode_t'(ri[DATAW-1 -: 3]);
    assign cd        = ri[ADDRW-1:0];
    assign ac_dec    = ac - 1'b1;
    assign ac_sum    = ac + temp;
    assign mem_wdata = ac;

    // Memory requests and halt indication follow the sequencer state; reset kills requests at once
    always_comb begin
        mem_addr = pc;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        stop     = 1'b0;
        case (state)
            S_I0: mem_rd = !rst;
            S_O0: begin
                mem_addr = cd;
                if (co == OP_ST) begin
                    mem_wr = !rst;
                end else begin
                    mem_rd = !rst;
                end
            end
            S_H:  stop = 1'b1;
            default: ;
        endcase
    end

    // Sequencer with the architectural registers; temp is only a staging register and is not reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_I0;
            pc    <= RESET_PC;
            ac    <= '0;
            z     <= 1'b1;
            ri    <= '0;
            leds  <= '0;
        end else begin
            leds <= ac[LEDW-1:0];
            case (state)
                S_I0: begin
                    if (mem_ready) begin
                        ri    <= mem_rdata;
                        pc    <= pc + 1'b1;
                        state <= S_I1;
                    end
                end
                S_I1: begin
                    case (co)
                        OP_ST, OP_LD, OP_ADD: state <= S_O0;
                        OP_BR: begin
                            pc    <= cd;
                            state <= S_I0;
                        end
                        OP_BZ: begin
                            if (z) begin
                                pc <= cd;
                            end
                            state <= S_I0;
                        end
                        OP_CLR: begin
                            ac    <= '0;
                            z     <= 1'b1;
                            state <= S_I0;
                        end
                        OP_DEC: begin
                            ac    <= ac_dec;
                            z     <= (ac_dec == '0);
                            state <= S_I0;
                        end
                        OP_HALT: state <= S_H;
                        default: state <= S_I0;
                    endcase
                end
                S_O0: begin
                    if (mem_ready) begin
                        if (co != OP_ST) begin
                            temp <= mem_rdata;
                        end
                        state <= S_O1;
                    end
                end
                S_O1: begin
                    if (co == OP_LD) begin
                        ac <= temp;
                        z  <= (temp == '0);
                    end else if (co == OP_ADD) begin
                        ac <= ac_sum;
                        z  <= (ac_sum == '0);
                    end
                    state <= S_I0;
                end
                S_H:     state <= S_H;
                default: state <= S_I0;
            endcase
        end
    end

endmodule

// File: tb/tb_simplez_cpu.sv
// Self-checking bench for simplez_cpu: bench-side memory, instruction-level
// reference model with cycle accounting, directed programs and random programs.
module tb_simplez_cpu;

    localparam int               ADDRW    = 9;
    localparam int               LEDW     = 4;
    localparam int               DATAW    = ADDRW + 3;
    localparam int               MEMSZ    = 1 << ADDRW;
    localparam logic [ADDRW-1:0] RESET_PC = '0;

    localparam logic [2:0] OP_ST = 3'd0, OP_LD = 3'd1, OP_ADD = 3'd2, OP_BR = 3'd3;
    localparam logic [2:0] OP_BZ = 3'd4, OP_CLR = 3'd5, OP_DEC = 3'd6, OP_HALT = 3'd7;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [ADDRW-1:0]   mem_addr;
    logic               mem_rd;
    logic               mem_wr;
    logic [DATAW-1:0]   mem_wdata;
    logic [DATAW-1:0]   mem_rdata = '0;
    logic               mem_ready = 1'b0;
    logic [LEDW-1:0]    leds;
    logic               stop;

    simplez_cpu #(.ADDRW(ADDRW), .LEDW(LEDW), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .leds(leds), .stop(stop)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    logic [DATAW-1:0]   mem [0:MEMSZ-1];
    int                 checks = 0;
    int                 passes = 0;
    int                 ready_mode = 0;
    int                 wait_ctr = 0;
    int                 cycle = 0;
    int                 first_stop = -1;
    int                 watch_addr = -1;
    int                 watch_hits = 0;
    logic [ADDRW-1:0]   addr_log [0:63];
    logic               rd_log [0:63];

    logic [ADDRW-1:0]   m_pc;
    logic [DATAW-1:0]   m_ac;
    logic               m_z;
    logic               m_halted;
    logic               m_opnd;
    logic [2:0]         m_co;
    logic [ADDRW-1:0]   m_cd;
    int                 m_base;
    int                 m_waits;
    int                 m_stop_cycle;
    logic               leds_pending;
    logic [DATAW-1:0]   leds_exp;

    logic               prev_wait;
    logic [ADDRW-1:0]   prev_addr;
    logic               prev_rd;
    logic               prev_wr;
    logic [DATAW-1:0]   prev_wdata;

    function automatic logic [DATAW-1:0] ins(input logic [2:0] op, input int cd);
        logic [31:0] c;
        c = cd;
        return {op, c[ADDRW-1:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_ac = '0; m_z = 1'b1; m_halted = 1'b0; m_opnd = 1'b0;
        m_co = 3'd0; m_cd = '0; m_base = 0; m_waits = 0; m_stop_cycle = 0;
        leds_pending = 1'b0; leds_exp = '0; prev_wait = 1'b0;
        cycle = 0; first_stop = -1; watch_hits = 0; wait_ctr = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEMSZ; i++) mem[i] = ins(OP_HALT, 0);
    endtask

    task automatic model_access(input logic is_wr, input logic [ADDRW-1:0] addr,
                                input logic [DATAW-1:0] wdata);
        logic [DATAW-1:0] instr;
        logic [DATAW-1:0] opnd;
        checkOutput("no_access_after_halt", m_halted, 0);
        if (m_halted) return;
        if (!m_opnd) begin
            checkOutput("fetch_addr", addr, m_pc);
            checkOutput("fetch_is_read", is_wr, 0);
            checkOutput("fetch_cycle", cycle, m_base + m_waits);
            instr        = mem[m_pc];
            leds_pending = 1'b1;
            leds_exp     = m_ac;
            m_pc         = m_pc + 1'b1;
            m_co         = instr[DATAW-1 -: 3];
            m_cd         = instr[ADDRW-1:0];
            case (m_co)
                OP_ST, OP_LD, OP_ADD: m_opnd = 1'b1;
                OP_BR:  begin m_pc = m_cd; m_base += 2; end
                OP_BZ:  begin if (m_z) m_pc = m_cd; m_base += 2; end
                OP_CLR: begin m_ac = '0; m_z = 1'b1; m_base += 2; end
                OP_DEC: begin m_ac = m_ac - 1'b1; m_z = (m_ac == '0); m_base += 2; end
                default: begin m_halted = 1'b1; m_stop_cycle = m_base + m_waits + 2; end
            endcase
        end else begin
            checkOutput("opnd_addr", addr, m_cd);
            checkOutput("opnd_is_write", is_wr, m_co == OP_ST);
            checkOutput("opnd_cycle", cycle, m_base + m_waits + 2);
            if (m_co == OP_ST) begin
                checkOutput("st_data", wdata, m_ac);
            end else begin
                opnd = mem[m_cd];
                m_ac = (m_co == OP_LD) ? opnd : m_ac + opnd;
                m_z  = (m_ac == '0);
            end
            m_opnd = 1'b0;
            m_base += 4;
        end
    endtask

    task automatic run_cycle(input logic rst_val);
        logic req;
        logic rdy;
        @(negedge clk);
        rst = rst_val;
        #1;
        if (rst) begin
            checkOutput("rst_forces_rd_low", mem_rd, 0);
            checkOutput("rst_forces_wr_low", mem_wr, 0);
            model_reset();
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
            return;
        end
        if (cycle < 64) begin
            addr_log[cycle] = mem_addr;
            rd_log[cycle]   = mem_rd;
        end
        if (cycle == 0) checkOutput("reset_leds", leds, 0);
        checkOutput("rd_wr_exclusive", mem_rd & mem_wr, 0);
        checkOutput("stop", stop, m_halted && (cycle >= m_stop_cycle));
        if (stop) begin
            if (first_stop < 0) first_stop = cycle;
            checkOutput("halt_no_request", mem_rd | mem_wr, 0);
            checkOutput("halt_leds", leds, m_ac[LEDW-1:0]);
        end
        if (leds_pending) begin
            checkOutput("leds", leds, leds_exp[LEDW-1:0]);
            leds_pending = 1'b0;
        end
        if (prev_wait) begin
            checkOutput("wait_addr_stable", mem_addr, prev_addr);
            checkOutput("wait_rd_stable", mem_rd, prev_rd);
            checkOutput("wait_wr_stable", mem_wr, prev_wr);
            checkOutput("wait_wdata_stable", mem_wdata, prev_wdata);
        end
        req = mem_rd | mem_wr;
        case (ready_mode)
            0: rdy = 1'b1;
            1: rdy = ($urandom_range(0, 3) != 0);
            2: begin
                if (req && wait_ctr < 3) begin
                    rdy = 1'b0;
                    wait_ctr++;
                end else begin
                    rdy = 1'b1;
                    wait_ctr = 0;
                end
            end
            default: rdy = !mem_wr;
        endcase
        if (req && !rdy) m_waits++;
        if (req && rdy) begin
            if (mem_rd && int'(mem_addr) == watch_addr) watch_hits++;
            model_access(mem_wr, mem_addr, mem_wdata);
            if (mem_wr) mem[mem_addr] = mem_wdata;
        end
        prev_wait  = req && !rdy;
        prev_addr  = mem_addr;
        prev_rd    = mem_rd;
        prev_wr    = mem_wr;
        prev_wdata = mem_wdata;
        mem_ready  = rdy;
        mem_rdata  = mem[mem_addr];
        cycle++;
    endtask

    task automatic applyStimulus(input int mode);
        ready_mode = mode;
        run_cycle(1'b1);
        run_cycle(1'b1);
    endtask

    task automatic run_until_stop(input int budget);
        int n;
        n = 0;
        while (first_stop < 0 && n < budget) begin
            run_cycle(1'b0);
            n++;
        end
        checkOutput("stop_reached", first_stop >= 0, 1);
        run_cycle(1'b0);
        run_cycle(1'b0);
    endtask

    // Directed programs first, then random programs with random wait states
    initial begin
        logic [DATAW-1:0] all_ones;
        logic [ADDRW-1:0] top;
        logic [31:0]      r;
        all_ones = '1;
        top      = '1;
        model_reset();

        clear_mem();
        mem[0] = ins(OP_CLR, 0); mem[1] = ins(OP_BZ, 20); mem[20] = ins(OP_HALT, 0);
        applyStimulus(0);
        run_until_stop(100);
        checkOutput("t1_first_addr", addr_log[0], RESET_PC);
        checkOutput("t1_first_rd", rd_log[0], 1);
        checkOutput("t1_decode_no_rd", rd_log[1], 0);
        checkOutput("t1_pc_after_2", addr_log[2], 1);
        checkOutput("t1_bz_taken", addr_log[4], 20);
        checkOutput("t1_stop_cycle", first_stop, 6);

        clear_mem();
        mem[0] = ins(OP_LD, 10); mem[1] = ins(OP_ADD, 11); mem[2] = ins(OP_ST, 12);
        mem[3] = ins(OP_HALT, 0); mem[10] = 5; mem[11] = 7; mem[12] = 0;
        applyStimulus(0);
        run_until_stop(100);
        checkOutput("t2_mem12", mem[12], 12);
        checkOutput("t2_leds", leds, 12);
        checkOutput("t2_stop_cycle", first_stop, 14);

        clear_mem();
        mem[0] = ins(OP_LD, 30); mem[1] = ins(OP_ADD, 31); mem[2] = ins(OP_ST, 33);
        mem[3] = ins(OP_BZ, 10); mem[10] = ins(OP_CLR, 0); mem[11] = ins(OP_DEC, 0);
        mem[12] = ins(OP_BZ, 40); mem[13] = ins(OP_ST, 32);
        mem[30] = all_ones; mem[31] = 1; mem[32] = 0; mem[33] = 'h5A5;
        applyStimulus(0);
        run_until_stop(100);
        checkOutput("t3_add_wrap", mem[33], 0);
        checkOutput("t3_dec_wrap", mem[32], all_ones);
        checkOutput("t3_stop_cycle", first_stop, 26);

        clear_mem();
        mem[0] = ins(OP_BZ, 5); mem[5] = ins(OP_BR, int'(top)); mem[top] = ins(OP_DEC, 0);
        mem[1] = ins(OP_HALT, 0);
        applyStimulus(0);
        run_until_stop(100);
        checkOutput("t4_br_top", addr_log[4], top);
        checkOutput("t4_pc_wrap", addr_log[6], 0);
        checkOutput("t4_bz_not_taken", addr_log[8], 1);
        checkOutput("t4_stop_cycle", first_stop, 10);

        clear_mem();
        mem[0] = ins(OP_LD, 60); mem[1] = ins(OP_DEC, 0); mem[2] = ins(OP_BZ, 4);
        mem[3] = ins(OP_BR, 1); mem[60] = 3;
        watch_addr = 1;
        applyStimulus(0);
        run_until_stop(200);
        checkOutput("t5_dec_count", watch_hits, 3);
        checkOutput("t5_stop_cycle", first_stop, 22);
        watch_addr = -1;

        clear_mem();
        mem[0] = ins(OP_LD, 10); mem[10] = 'h0AC;
        applyStimulus(2);
        run_until_stop(200);
        checkOutput("t6_operand_addr", addr_log[5], 10);
        checkOutput("t6_o1_no_rd", rd_log[9], 0);
        checkOutput("t6_next_fetch", addr_log[10], 1);
        checkOutput("t6_stop_cycle", first_stop, 15);
        checkOutput("t6_leds", leds, 'h0AC & ((1 << LEDW) - 1));

        clear_mem();
        mem[0] = ins(OP_LD, 70); mem[1] = ins(OP_ST, 71); mem[70] = 'h123; mem[71] = 'h055;
        applyStimulus(3);
        for (int i = 0; i < 7; i++) run_cycle(1'b0);
        checkOutput("t7_st_pending", mem_wr, 1);
        run_cycle(1'b1);
        checkOutput("t7_wr_dropped", mem_wr, 0);
        run_cycle(1'b1);
        checkOutput("t7_word_unchanged", mem[71], 'h055);
        ready_mode = 0;
        run_cycle(1'b0);
        checkOutput("t7_refetch_addr", addr_log[0], RESET_PC);
        checkOutput("t7_refetch_rd", rd_log[0], 1);
        run_until_stop(100);
        checkOutput("t7_rerun_store", mem[71], 'h123);

        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < MEMSZ; i++) begin
                r = $urandom;
                mem[i] = r[DATAW-1:0];
            end
            applyStimulus(1);
            for (int c = 0; c < 300; c++) run_cycle(1'b0);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
